// File: rtl/lcd_pkg.sv
// Shared HD44780 command set, top-level state enum and timing/format helpers
// for the character-LCD frame writer.
package lcd_pkg;

  localparam logic [7:0] CMD_WAKE  = 8'h30;
  localparam logic [7:0] FUNC_8B2L = 8'h38;
  localparam logic [7:0] DISP_OFF  = 8'h08;
  localparam logic [7:0] CLEAR     = 8'h01;
  localparam logic [7:0] HOME      = 8'h02;
  localparam logic [7:0] ENTRY_INC = 8'h06;
  localparam logic [7:0] DISP_ON   = 8'h0C;
  localparam logic [7:0] LINE1     = 8'h80;
  localparam logic [7:0] LINE2     = 8'hC0;
  localparam logic [7:0] CH_SPACE  = 8'h20;

  localparam int INIT_LEN   = 8;
  localparam int LINE_CHARS = 16;
  // set-address command plus 16 characters, for each of the two lines
  localparam int FRAME_LEN  = 2 * (LINE_CHARS + 1);

  typedef enum logic [1:0] {S_PWR_WAIT, S_INIT, S_READY, S_DRAW} lcd_state_t;

  function automatic logic [7:0] nibble_to_hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    return 8'h37 + {4'h0, nib};
  endfunction

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: return CMD_WAKE;
      3'd3:             return FUNC_8B2L;
      3'd4:             return DISP_OFF;
      3'd5:             return CLEAR;
      3'd6:             return ENTRY_INC;
      default:          return DISP_ON;
    endcase
  endfunction

  // Rounds up so a wait is never shorter than asked for; never returns 0.
  function automatic int us_to_cycles(input longint clk_hz, input longint us);
    longint c;
    c = (clk_hz * us + 64'd999_999) / 64'd1_000_000;
    return (c < 1) ? 1 : int'(c);
  endfunction

endpackage

// File: rtl/lcd_write_strobe.sv
// One HD44780 bus write: setup with EN low, EN pulse, then the post-write
// wait (long for clear/home). Pulses ack when the controller is ready again.
module lcd_write_strobe
  import lcd_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int CMD_US    = 50,
  parameter int CLR_US    = 2000,
  parameter int EN_CYC    = 50,
  parameter int SETUP_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       ack,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_en
);

  localparam int CMD_CYC = us_to_cycles(CLK_HZ, CMD_US);
  localparam int CLR_CYC = us_to_cycles(CLK_HZ, CLR_US);
  localparam int MAX_W   = (CLR_CYC > CMD_CYC) ? CLR_CYC : CMD_CYC;
  localparam int MAX_E   = (EN_CYC > SETUP_CYC) ? EN_CYC : SETUP_CYC;
  localparam int MAX_CYC = (MAX_W > MAX_E) ? MAX_W : MAX_E;
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {W_IDLE, W_SETUP, W_EN, W_WAIT} wphase_t;

  wphase_t       r_ph;
  logic [CW-1:0] r_cnt;
  logic          r_long;
  logic [7:0]    r_data;
  logic          r_rs;
  logic          r_en;
  logic          r_ack;

  // DATA/RS are latched once per write and held until the next request,
  // so they stay stable through setup, the EN pulse and the wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ph   <= W_IDLE;
      r_cnt  <= '0;
      r_long <= 1'b0;
      r_data <= 8'h00;
      r_rs   <= 1'b0;
      r_en   <= 1'b0;
      r_ack  <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_ph)
        W_IDLE: if (req) begin
          r_data <= data;
          r_rs   <= rs;
          r_long <= long_wait;
          r_cnt  <= CW'(SETUP_CYC - 1);
          r_ph   <= W_SETUP;
        end
        W_SETUP: if (r_cnt == '0) begin
          r_en  <= 1'b1;
          r_cnt <= CW'(EN_CYC - 1);
          r_ph  <= W_EN;
        end else r_cnt <= r_cnt - 1'b1;
        W_EN: if (r_cnt == '0) begin
          r_en  <= 1'b0;
          r_cnt <= r_long ? CW'(CLR_CYC - 1) : CW'(CMD_CYC - 1);
          r_ph  <= W_WAIT;
        end else r_cnt <= r_cnt - 1'b1;
        W_WAIT: if (r_cnt == '0) begin
          r_ack <= 1'b1;
          r_ph  <= W_IDLE;
        end else r_cnt <= r_cnt - 1'b1;
        default: r_ph <= W_IDLE;
      endcase
    end
  end

  assign ack      = r_ack;
  assign lcd_data = r_data;
  assign lcd_rs   = r_rs;
  assign lcd_en   = r_en;

endmodule

// File: rtl/lcd_frame_writer.sv
// HD44780 init + two-line "a=XX n=XX" / "res=XXXX" frame writer with busy/done.
// Optional LCD_AUTO_REFRESH_EN: redraw by itself when live inputs differ from the snapshot.
module lcd_frame_writer
  import lcd_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int A_W       = 8,
  parameter int N_W       = 8,
  parameter int R_W       = 16,
  parameter int PWR_US    = 15000,
  parameter int CMD_US    = 50,
  parameter int CLR_US    = 2000,
  parameter int EN_CYC    = 50,
  parameter int SETUP_CYC = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [A_W-1:0] a_in,
  input  logic [N_W-1:0] n_in,
  input  logic [R_W-1:0] res_in,
  output logic           busy,
  output logic           done,
  output logic [7:0]     LCD_DATA,
  output logic           LCD_EN,
  output logic           LCD_RS,
  output logic           LCD_RW,
  output logic           LCD_ON,
  output logic           LCD_BLON
);

  localparam int DA = (A_W + 3) / 4;
  localparam int DN = (N_W + 3) / 4;
  localparam int DR = (R_W + 3) / 4;
  localparam int AP = 4 * DA;
  localparam int NP = 4 * DN;
  localparam int RP = 4 * DR;
  localparam int PWR_CYC = us_to_cycles(CLK_HZ, PWR_US);
  localparam int PW      = $clog2(PWR_CYC + 1);

  if (5 + DA + DN > LINE_CHARS || 4 + DR > LINE_CHARS) begin : g_fit_check
    $error("lcd_frame_writer: operand fields do not fit a 16-column line");
  end

  lcd_state_t    r_state;
  logic [PW-1:0] r_cnt;
  logic [5:0]    r_step;
  logic          r_req;
  logic          r_wait;
  logic          r_pend;
  logic          r_busy;
  logic          r_done;
  logic [AP-1:0] r_a;
  logic [NP-1:0] r_n;
  logic [RP-1:0] r_r;
  logic [7:0]    r_wdata;
  logic          r_wrs;
  logic          r_wlong;

  logic          w_ack;
  logic          w_auto;
  logic [7:0]    w_byte;
  logic          w_rs;
  logic          w_long;
  logic [5:0]    w_last;
  int            s;
  int            col;

`ifdef LCD_AUTO_REFRESH_EN
  assign w_auto = (AP'(a_in) != r_a) || (NP'(n_in) != r_n) || (RP'(res_in) != r_r);
`else
  assign w_auto = 1'b0;
`endif

  // Byte for the current step: an init command, or a frame position.
  always_comb begin
    w_byte = CH_SPACE;
    w_rs   = 1'b1;
    s      = int'(r_step);
    col    = 0;
    if (r_state == S_INIT) begin
      w_byte = init_cmd(r_step[2:0]);
      w_rs   = 1'b0;
    end else if (s == 0) begin
      w_byte = LINE1;
      w_rs   = 1'b0;
    end else if (s == LINE_CHARS + 1) begin
      w_byte = LINE2;
      w_rs   = 1'b0;
    end else if (s <= LINE_CHARS) begin
      col = s - 1;
      if (col == 0)                w_byte = "a";
      else if (col == 1)           w_byte = "=";
      else if (col < 2 + DA)       w_byte = nibble_to_hex_ascii(4'(r_a >> (4 * (DA + 1 - col))));
      else if (col == 2 + DA)      w_byte = " ";
      else if (col == 3 + DA)      w_byte = "n";
      else if (col == 4 + DA)      w_byte = "=";
      else if (col < 5 + DA + DN)  w_byte = nibble_to_hex_ascii(4'(r_n >> (4 * (DN + DA + 4 - col))));
    end else begin
      col = s - (LINE_CHARS + 2);
      if (col == 0)                w_byte = "r";
      else if (col == 1)           w_byte = "e";
      else if (col == 2)           w_byte = "s";
      else if (col == 3)           w_byte = "=";
      else if (col < 4 + DR)       w_byte = nibble_to_hex_ascii(4'(r_r >> (4 * (DR + 3 - col))));
    end
  end

  assign w_long = !w_rs && (w_byte == CLEAR || w_byte == HOME);
  assign w_last = (r_state == S_INIT) ? 6'(INIT_LEN - 1) : 6'(FRAME_LEN - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_PWR_WAIT;
      r_cnt   <= '0;
      r_step  <= '0;
      r_req   <= 1'b0;
      r_wait  <= 1'b0;
      r_pend  <= 1'b0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_a     <= '0;
      r_n     <= '0;
      r_r     <= '0;
      r_wdata <= 8'h00;
      r_wrs   <= 1'b0;
      r_wlong <= 1'b0;
    end else begin
      r_req  <= 1'b0;
      r_done <= 1'b0;
      // requests outside READY collapse into one pending redraw
      if (start && r_state != S_READY) r_pend <= 1'b1;
      case (r_state)
        S_PWR_WAIT: begin
          if (r_cnt == PW'(PWR_CYC - 1)) begin
            r_state <= S_INIT;
            r_step  <= '0;
            r_wait  <= 1'b0;
          end else r_cnt <= r_cnt + 1'b1;
        end
        S_INIT, S_DRAW: begin
          if (!r_wait) begin
            r_req   <= 1'b1;
            r_wait  <= 1'b1;
            r_wdata <= w_byte;
            r_wrs   <= w_rs;
            r_wlong <= w_long;
          end else if (w_ack) begin
            r_wait <= 1'b0;
            if (r_step == w_last) begin
              r_step  <= '0;
              r_state <= S_READY;
              r_busy  <= 1'b0;
              r_done  <= (r_state == S_DRAW);
            end else r_step <= r_step + 1'b1;
          end
        end
        S_READY: begin
          if (start || r_pend || w_auto) begin
            r_a     <= AP'(a_in);
            r_n     <= NP'(n_in);
            r_r     <= RP'(res_in);
            r_pend  <= 1'b0;
            r_busy  <= 1'b1;
            r_step  <= '0;
            r_wait  <= 1'b0;
            r_state <= S_DRAW;
          end
        end
        default: r_state <= S_PWR_WAIT;
      endcase
    end
  end

  lcd_write_strobe #(
    .CLK_HZ   (CLK_HZ),
    .CMD_US   (CMD_US),
    .CLR_US   (CLR_US),
    .EN_CYC   (EN_CYC),
    .SETUP_CYC(SETUP_CYC)
  ) u_strobe (
    .clk      (clk),
    .rst      (rst),
    .req      (r_req),
    .rs       (r_wrs),
    .data     (r_wdata),
    .long_wait(r_wlong),
    .ack      (w_ack),
    .lcd_data (LCD_DATA),
    .lcd_rs   (LCD_RS),
    .lcd_en   (LCD_EN)
  );

  assign busy     = r_busy;
  assign done     = r_done;
  assign LCD_RW   = 1'b0;
  assign LCD_ON   = 1'b1;
  assign LCD_BLON = 1'b1;

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Bench for lcd_frame_writer: bus monitor captures every EN pulse; expected
// frames are built as text strings and compared write by write.
module tb_lcd_frame_writer;

  localparam int CLK_HZ    = 1_000_000;
  localparam int PWR_US    = 100;
  localparam int CMD_US    = 5;
  localparam int CLR_US    = 20;
  localparam int EN_CYC    = 3;
  localparam int SETUP_CYC = 2;
  localparam int PWR_CYC   = 100;
  localparam int CMD_CYC   = 5;
  localparam int CLR_CYC   = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  a_in = 8'h00;
  logic [7:0]  n_in = 8'h00;
  logic [15:0] res_in = 16'h0000;
  logic        busy, done, LCD_EN, LCD_RS, LCD_RW, LCD_ON, LCD_BLON;
  logic [7:0]  LCD_DATA;

  lcd_frame_writer #(
    .CLK_HZ(CLK_HZ), .A_W(8), .N_W(8), .R_W(16), .PWR_US(PWR_US),
    .CMD_US(CMD_US), .CLR_US(CLR_US), .EN_CYC(EN_CYC), .SETUP_CYC(SETUP_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .n_in(n_in), .res_in(res_in),
    .busy(busy), .done(done), .LCD_DATA(LCD_DATA), .LCD_EN(LCD_EN), .LCD_RS(LCD_RS),
    .LCD_RW(LCD_RW), .LCD_ON(LCD_ON), .LCD_BLON(LCD_BLON)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] d; logic rs; int rise; int hi; bit ok; } wr_t;
  typedef struct { logic [7:0] d; logic rs; int gap; } exp_t;

  wr_t  wq[$];
  exp_t eq[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   done_cnt = 0;
  int   done_bad = 0;

  // Bus monitor: one record per EN pulse, with setup/hold and width observed.
  initial begin : mon
    logic [7:0] pd, d0;
    logic prs, rs0;
    int quiet, hi, rise;
    bit in_hi, ok;
    wr_t w;
    pd = 8'h00; d0 = 8'h00; prs = 1'b0; rs0 = 1'b0;
    quiet = 0; hi = 0; rise = 0; in_hi = 1'b0; ok = 1'b0;
    forever begin
      @(negedge clk);
      if (LCD_DATA !== pd || LCD_RS !== prs) quiet = 0; else quiet++;
      pd = LCD_DATA; prs = LCD_RS;
      if (done === 1'b1) begin
        done_cnt++;
        if (busy !== 1'b0) done_bad++;
      end
      if (rst) in_hi = 1'b0;
      else if (LCD_EN === 1'b1) begin
        if (!in_hi) begin
          in_hi = 1'b1; hi = 1; d0 = LCD_DATA; rs0 = LCD_RS;
          ok = (quiet >= SETUP_CYC); rise = cyc;
        end else begin
          hi++;
          if (LCD_DATA !== d0 || LCD_RS !== rs0) ok = 1'b0;
        end
      end else if (in_hi) begin
        in_hi = 1'b0;
        w.d = d0; w.rs = rs0; w.rise = rise; w.hi = hi; w.ok = ok;
        wq.push_back(w);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete (cyc=%0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [7:0] d, input logic rs);
    exp_t e;
    e.d = d; e.rs = rs;
    e.gap = EN_CYC + ((!rs && (d == 8'h01 || d == 8'h02)) ? CLR_CYC : CMD_CYC);
    eq.push_back(e);
  endtask

  task automatic exp_init();
    logic [7:0] cmds [8];
    cmds = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
    foreach (cmds[i]) push_exp(cmds[i], 1'b0);
  endtask

  task automatic exp_frame(input logic [7:0] a, input logic [7:0] n, input logic [15:0] r);
    string ha, hn, hr, l1, l2;
    ha = $sformatf("%02h", a); ha = ha.toupper();
    hn = $sformatf("%02h", n); hn = hn.toupper();
    hr = $sformatf("%04h", r); hr = hr.toupper();
    l1 = {"a=", ha, " n=", hn};
    l2 = {"res=", hr};
    while (l1.len() < 16) l1 = {l1, " "};
    while (l2.len() < 16) l2 = {l2, " "};
    push_exp(8'h80, 1'b0);
    for (int i = 0; i < 16; i++) push_exp(l1[i], 1'b1);
    push_exp(8'hC0, 1'b0);
    for (int i = 0; i < 16; i++) push_exp(l2[i], 1'b1);
  endtask

  task automatic expect_writes(input string tag, input int base, input int budget);
    int n;
    n = eq.size();
    for (int k = 0; k < budget && wq.size() < base + n; k++) @(posedge clk);
    vectors++;
    if (wq.size() < base + n) begin
      miscompares++;
      $display("FAIL %s write count: got %0d want %0d", tag, wq.size() - base, n);
    end
    for (int i = 0; i < n && base + i < wq.size(); i++) begin
      vectors++;
      if ({wq[base+i].rs, wq[base+i].d} !== {eq[i].rs, eq[i].d}) begin
        miscompares++;
        $display("FAIL %s write %0d: got rs=%0b data=%02h want rs=%0b data=%02h",
                 tag, i, wq[base+i].rs, wq[base+i].d, eq[i].rs, eq[i].d);
      end
      vectors++;
      if (wq[base+i].hi != EN_CYC || !wq[base+i].ok) begin
        miscompares++;
        $display("FAIL %s strobe %0d: got en_high=%0d stable=%0b want en_high=%0d stable=1",
                 tag, i, wq[base+i].hi, wq[base+i].ok, EN_CYC);
      end
      if (i + 1 < n && base + i + 1 < wq.size()) begin
        vectors++;
        if (wq[base+i+1].rise - wq[base+i].rise < eq[i].gap) begin
          miscompares++;
          $display("FAIL %s gap after %0d (%02h): got %0d want >=%0d", tag, i, eq[i].d,
                   wq[base+i+1].rise - wq[base+i].rise, eq[i].gap);
        end
      end
    end
    eq.delete();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    for (k = 0; k < budget && busy !== 1'b0; k++) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle: busy still %0b after %0d cycles, want 0", tag, busy, budget);
    end
  endtask

  task automatic run_init(input string tag, input bit with_start);
    int db, base, t0;
    db = done_cnt; base = wq.size(); t0 = cyc;
    rst = 1'b0;
    if (with_start) begin
      repeat (10) @(negedge clk);
      start = 1'b1; @(negedge clk); start = 1'b0;
    end
    exp_init();
    if (with_start) exp_frame(a_in, n_in, res_in);
    expect_writes(tag, base, 4000);
    vectors++;
    if (wq.size() <= base || wq[base].rise - t0 < PWR_CYC) begin
      miscompares++;
      $display("FAIL %s power-up wait: got first EN at %0d cycles want >=%0d",
               tag, (wq.size() > base) ? wq[base].rise - t0 : -1, PWR_CYC);
    end
    wait_idle(tag, 200);
    vectors++;
    if (done_cnt - db != (with_start ? 1 : 0)) begin
      miscompares++;
      $display("FAIL %s done pulses: got %0d want %0d", tag, done_cnt - db, with_start ? 1 : 0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({LCD_DATA, LCD_EN, LCD_RS, LCD_RW, LCD_ON, LCD_BLON, busy, done} !== 14'b00000000_0001_1_1_0 >> 0
        && {LCD_DATA, LCD_EN, LCD_RS, LCD_RW, LCD_ON, LCD_BLON, busy, done} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset state: got data=%02h en=%0b rs=%0b rw=%0b on=%0b blon=%0b busy=%0b done=%0b want 00 0 0 0 1 1 1 0",
               LCD_DATA, LCD_EN, LCD_RS, LCD_RW, LCD_ON, LCD_BLON, busy, done);
    end
    run_init("init", 1'b0);
  endtask

  task automatic test_frame(input string tag, input logic [7:0] a, input logic [7:0] n, input logic [15:0] r);
    int db, dbad, base;
    a_in = a; n_in = n; res_in = r;
    db = done_cnt; dbad = done_bad; base = wq.size();
    start = 1'b1; @(negedge clk); start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s busy after accept: got %0b want 1", tag, busy);
    end
    exp_frame(a, n, r);
    expect_writes(tag, base, 2000);
    wait_idle(tag, 200);
    vectors++;
    if (done_cnt - db != 1 || done_bad != dbad) begin
      miscompares++;
      $display("FAIL %s done: got pulses=%0d with_busy=%0d want 1 and 0", tag, done_cnt - db, done_bad - dbad);
    end
  endtask

  task automatic test_snapshot();
    int base;
    a_in = 8'h2F; n_in = 8'h03; res_in = 16'hBEEF;
    base = wq.size();
    start = 1'b1; @(negedge clk); start = 1'b0;
    @(posedge clk); #1 a_in = 8'h11;
    fork
      begin repeat (200) @(posedge clk); a_in = 8'h2F; end
    join_none
    exp_frame(8'h2F, 8'h03, 16'hBEEF);
    expect_writes("snapshot", base, 2000);
    wait_idle("snapshot", 300);
  endtask

  task automatic test_back_to_back();
    int db, base, k;
    logic [7:0] a1, n1, a2, n2;
    logic [15:0] r1, r2;
    a1 = 8'($urandom); n1 = 8'($urandom); r1 = 16'($urandom);
    a2 = 8'($urandom); n2 = 8'($urandom); r2 = 16'($urandom);
    a_in = a1; n_in = n1; res_in = r1;
    db = done_cnt; base = wq.size();
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (k = 0; k < 1000 && wq.size() < base + 3; k++) @(negedge clk);
    repeat (3) begin
      start = 1'b1; @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
    end
    a_in = a2; n_in = n2; res_in = r2;
    exp_frame(a1, n1, r1);
    exp_frame(a2, n2, r2);
    expect_writes("back_to_back", base, 4000);
    wait_idle("back_to_back", 300);
    repeat (100) @(negedge clk);
    vectors++;
    if (wq.size() - base != 68 || done_cnt - db != 2) begin
      miscompares++;
      $display("FAIL back_to_back frames: got writes=%0d done=%0d want 68 and 2", wq.size() - base, done_cnt - db);
    end
  endtask

  task automatic test_reset_mid();
    int base, k;
    a_in = 8'($urandom); n_in = 8'($urandom); res_in = 16'($urandom);
    base = wq.size();
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (k = 0; k < 3000 && !(wq.size() >= base + 5 && LCD_EN === 1'b1); k++) @(negedge clk);
    vectors++;
    if (LCD_EN !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid: no EN-high phase seen, got en=%0b want 1", LCD_EN);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({LCD_EN, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL reset_mid edge: got en=%0b busy=%0b want en=0 busy=1", LCD_EN, busy);
    end
    @(negedge clk);
    run_init("reinit", 1'b1);
  endtask

`ifdef LCD_AUTO_REFRESH_EN
  task automatic test_auto_refresh();
    int db, base;
    res_in = 16'h0001;
    base = wq.size();
    exp_frame(a_in, n_in, 16'h0001);
    expect_writes("auto_0001", base, 2000);
    wait_idle("auto_0001", 300);
    db = done_cnt; base = wq.size();
    res_in = 16'h0002;
    exp_frame(a_in, n_in, 16'h0002);
    expect_writes("auto_0002", base, 2000);
    wait_idle("auto_0002", 300);
    repeat (200) @(negedge clk);
    vectors++;
    if (wq.size() - base != 34 || done_cnt - db != 1) begin
      miscompares++;
      $display("FAIL auto_refresh: got writes=%0d done=%0d want 34 and 1", wq.size() - base, done_cnt - db);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame("frame_2F_03_BEEF", 8'h2F, 8'h03, 16'hBEEF);
    test_frame("frame_zero", 8'h00, 8'h00, 16'h0000);
    test_frame("frame_ones", 8'hFF, 8'hFF, 16'hFFFF);
    for (int i = 0; i < 3; i++)
      test_frame($sformatf("frame_rand%0d", i), 8'($urandom), 8'($urandom), 16'($urandom));
    test_snapshot();
    test_back_to_back();
    test_reset_mid();
`ifdef LCD_AUTO_REFRESH_EN
    test_auto_refresh();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
